vga_text_renderer: RTL and testbench

//   Downstream consumer of the 80x30 tile buffer. Takes beam position from the sync generator, drives
//   col/row read addresses into the buffer, looks up the returned 7-bit char code in an external 8x16

---
 rtl/vga_text_renderer.sv | 129 ++++++++++++
 tb/tb_vga_text_renderer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_renderer.sv
// Text-mode pixel pipeline: beam position -> tile address -> font ROM -> pixel.
// Syncs and DE are delayed to stay aligned with pixels; optional blinking block cursor.
module vga_text_renderer #(
    parameter int                 COLOR_W      = 3,
    parameter logic [COLOR_W-1:0] FG_COLOR     = 3'b111,
    parameter logic [COLOR_W-1:0] BG_COLOR     = 3'b000,
    parameter int                 BLINK_FRAMES = 30
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [9:0]         hpos_i,
    input  logic [9:0]         vpos_i,
    input  logic               de_i,
    input  logic               hsync_i,
    input  logic               vsync_i,
    output logic [6:0]         col_r_o,
    output logic [4:0]         row_r_o,
    input  logic [6:0]         char_i,
    output logic [10:0]        font_addr_o,
    input  logic [7:0]         font_data_i,
    input  logic               cursor_en_i,
    input  logic [6:0]         cursor_col_i,
    input  logic [4:0]         cursor_row_i,
    output logic [COLOR_W-1:0] rgb_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               de_o
);

    localparam int               CNT_W    = $clog2(BLINK_FRAMES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic             addr_en;
    logic             cursor_hit;
    logic             unused_vpos_msb;

    logic [2:0]       hbit_s1;
    logic [3:0]       vline_s1;
    logic             de_s1, hs_s1, vs_s1, hit_s1;

    logic [2:0]       hbit_s2;
    logic             de_s2, hs_s2, vs_s2, hit_s2;

    logic             font_bit;
    logic             pix;

    logic             vs_prev;
    logic             vsync_fall;
    logic [CNT_W-1:0] blink_cnt;
    logic             blink_on;

    // Rows only need vpos[8:4]; bit 9 is only meaningful in vertical blanking.
    assign unused_vpos_msb = vpos_i[9];

    // Stage 0: tile address straight from the beam, forced to 0 while blanked or in reset.
    assign addr_en    = de_i && !rst_i;
    assign col_r_o    = addr_en ? hpos_i[9:3] : '0;
    assign row_r_o    = addr_en ? vpos_i[8:4] : '0;
    assign cursor_hit = cursor_en_i && (col_r_o == cursor_col_i) && (row_r_o == cursor_row_i);

    // Stage 1 -> font ROM address: char_i arrives one clock after col/row.
    assign font_addr_o = rst_i ? '0 : {char_i, vline_s1};

    // Stage 3 pixel select: MSB of the glyph line is the leftmost pixel.
    assign font_bit = font_data_i[3'd7 - hbit_s2];
    assign pix      = font_bit ^ (hit_s2 && blink_on);

    // NOTE: all pipeline state uses non-blocking assignments so every stage samples
    // the previous stage's value from before the edge, giving exact 1-clock steps.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hbit_s1  <= '0;
            vline_s1 <= '0;
            de_s1    <= 1'b0;
            hs_s1    <= 1'b1;
            vs_s1    <= 1'b1;
            hit_s1   <= 1'b0;
            hbit_s2  <= '0;
            de_s2    <= 1'b0;
            hs_s2    <= 1'b1;
            vs_s2    <= 1'b1;
            hit_s2   <= 1'b0;
            rgb_o    <= '0;
            hsync_o  <= 1'b1;
            vsync_o  <= 1'b1;
            de_o     <= 1'b0;
        end else begin
            hbit_s1  <= hpos_i[2:0];
            vline_s1 <= vpos_i[3:0];
            de_s1    <= de_i;
            hs_s1    <= hsync_i;
            vs_s1    <= vsync_i;
            hit_s1   <= cursor_hit;

            hbit_s2  <= hbit_s1;
            de_s2    <= de_s1;
            hs_s2    <= hs_s1;
            vs_s2    <= vs_s1;
            hit_s2   <= hit_s1;

            rgb_o    <= de_s2 ? (pix ? FG_COLOR : BG_COLOR) : '0;
            hsync_o  <= hs_s2;
            vsync_o  <= vs_s2;
            de_o     <= de_s2;
        end
    end

    // Cursor blink: one count per frame, taken on the vsync falling edge.
    assign vsync_fall = vs_prev && !vsync_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vs_prev   <= 1'b1;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            vs_prev <= vsync_i;
            if (vsync_fall) begin
                if (blink_cnt == CNT_LAST) begin
                    blink_cnt <= '0;
                    blink_on  <= !blink_on;
                end else begin
                    blink_cnt <= blink_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_text_renderer.sv
// Bench for vga_text_renderer: emulates the tile buffer and font ROM, predicts every
// output pixel/sync from position, tile contents, glyph bits and cursor/blink state.
module tb_vga_text_renderer;

    localparam int BF = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [9:0]  hpos_i = '0;
    logic [9:0]  vpos_i = '0;
    logic        de_i = 1'b0;
    logic        hsync_i = 1'b1;
    logic        vsync_i = 1'b1;
    logic [6:0]  col_r_o;
    logic [4:0]  row_r_o;
    logic [6:0]  char_i = '0;
    logic [10:0] font_addr_o;
    logic [7:0]  font_data_i = '0;
    logic        cursor_en_i = 1'b0;
    logic [6:0]  cursor_col_i = '0;
    logic [4:0]  cursor_row_i = '0;
    logic [2:0]  rgb_o;
    logic        hsync_o, vsync_o, de_o;

    vga_text_renderer #(
        .COLOR_W(3), .FG_COLOR(3'b111), .BG_COLOR(3'b000), .BLINK_FRAMES(BF)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .hpos_i(hpos_i), .vpos_i(vpos_i), .de_i(de_i),
        .hsync_i(hsync_i), .vsync_i(vsync_i),
        .col_r_o(col_r_o), .row_r_o(row_r_o), .char_i(char_i),
        .font_addr_o(font_addr_o), .font_data_i(font_data_i),
        .cursor_en_i(cursor_en_i), .cursor_col_i(cursor_col_i), .cursor_row_i(cursor_row_i),
        .rgb_o(rgb_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o)
    );

    always #5 clk_i = ~clk_i;

    // Tile buffer (indexed {row, col}) and font ROM, both one-clock synchronous reads.
    logic [6:0] tile_mem [0:4095];
    logic [7:0] font_rom [0:2047];

    always @(posedge clk_i) begin
        char_i      <= tile_mem[{row_r_o, col_r_o}];
        font_data_i <= font_rom[font_addr_o];
    end

    typedef struct {
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
        logic       de;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   falls  = 0;
    logic prev_vs = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pixel colour from the text-mode rules: glyph bit, cursor inversion, blink phase.
    function automatic logic [2:0] ref_pixel(input int hp, input int vp, input logic de);
        int   col, row, ch;
        logic fbit, hit, blink;
        if (!de) return 3'b000;
        col   = hp / 8;
        row   = (vp / 16) % 32;
        ch    = int'(tile_mem[row * 128 + col]);
        fbit  = font_rom[ch * 16 + vp % 16][7 - hp % 8];
        hit   = cursor_en_i && (col == int'(cursor_col_i)) && (row == int'(cursor_row_i));
        blink = ((falls / BF) % 2) == 0;
        return (fbit ^ (hit && blink)) ? 3'b111 : 3'b000;
    endfunction

    // One pixel clock: check the output due now (3 clocks old), drive the next beam sample.
    task automatic step(input int hp, input int vp, input logic de, input logic hs, input logic vs);
        exp_t e;
        if (exp_q.size() == 3) begin
            e = exp_q.pop_front();
            check("rgb", rgb_o, e.rgb);
            check("hsync", hsync_o, e.hs);
            check("vsync", vsync_o, e.vs);
            check("de", de_o, e.de);
        end
        if (prev_vs && !vs) falls++;
        prev_vs = vs;
        hpos_i  = 10'(hp);
        vpos_i  = 10'(vp);
        de_i    = de;
        hsync_i = hs;
        vsync_i = vs;
        e.rgb = ref_pixel(hp, vp, de);
        e.hs  = hs;
        e.vs  = vs;
        e.de  = de;
        exp_q.push_back(e);
        @(negedge clk_i);
    endtask

    // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
    task automatic apply_reset();
        exp_t blank;
        #2 rst_i = 1'b1;
        #1;
        check("rst_rgb", rgb_o, 0);
        check("rst_de", de_o, 0);
        check("rst_hsync", hsync_o, 1);
        check("rst_vsync", vsync_o, 1);
        check("rst_col", col_r_o, 0);
        check("rst_row", row_r_o, 0);
        check("rst_faddr", font_addr_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_q.delete();
        blank.rgb = 3'b000;
        blank.hs  = 1'b1;
        blank.vs  = 1'b1;
        blank.de  = 1'b0;
        repeat (3) exp_q.push_back(blank);
        falls   = 0;
        prev_vs = 1'b1;
    endtask

    // Shortened frame: 16 active lines of 6 tiles, short hblank, vblank with a vsync pulse.
    task automatic mini_frame();
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 48; x++) step(x, y, 1'b1, 1'b1, 1'b1);
            for (int x = 640; x < 652; x++) step(x, y, 1'b0, !(x >= 644 && x < 648), 1'b1);
        end
        for (int k = 0; k < 16; k++) step(640 + k, 490, 1'b0, 1'b1, !(k >= 4 && k < 8));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) tile_mem[i] = 7'($urandom);
        for (int i = 0; i < 2048; i++) font_rom[i] = 8'($urandom);
        tile_mem[{5'd29, 7'd79}] = 7'h41;
        tile_mem[{5'd0, 7'd1}]   = 7'h7F;
        tile_mem[{5'd0, 7'd0}]   = 7'h41;
        font_rom[11'h410]        = 8'h81;
        font_rom[11'h411]        = 8'hFF;

        apply_reset();

        // Addressing at the bottom-right tile and the top of the font space.
        step(639, 479, 1'b1, 1'b1, 1'b1);
        check("col_max", col_r_o, 79);
        check("row_max", row_r_o, 29);
        check("faddr_41F", font_addr_o, 11'h41F);
        step(8, 15, 1'b1, 1'b1, 1'b1);
        check("faddr_7FF", font_addr_o, 11'h7FF);
        step(639, 479, 1'b0, 1'b1, 1'b1);
        check("col_blank", col_r_o, 0);
        check("row_blank", row_r_o, 0);

        // Glyph 0x81 across tile 0, then blanked line with all-ones font and a 96-clk hsync.
        for (int x = 0; x < 8; x++) step(x, 0, 1'b1, 1'b1, 1'b1);
        for (int x = 640; x < 800; x++) step(x, 1, 1'b0, !(x >= 656 && x < 752), 1'b1);

        // Reset asserted in the middle of an active line with hsync low.
        for (int x = 0; x < 10; x++) step(x, 2, 1'b1, 1'b0, 1'b1);
        apply_reset();

        // Random beam positions, half of them aimed at the current cursor tile.
        for (int n = 0; n < 3000; n++) begin
            int hp, vp;
            if (n % 64 == 0) begin
                cursor_en_i  = 1'($urandom_range(0, 1));
                cursor_col_i = 7'($urandom_range(0, 79));
                cursor_row_i = 5'($urandom_range(0, 29));
            end
            if ($urandom_range(0, 1) == 1) begin
                hp = int'(cursor_col_i) * 8 + int'($urandom_range(0, 7));
                vp = int'(cursor_row_i) * 16 + int'($urandom_range(0, 15));
            end else begin
                hp = int'($urandom_range(0, 799));
                vp = int'($urandom_range(0, 524));
            end
            step(hp, vp, (hp < 640) && (vp < 480), $urandom_range(0, 3) != 0, 1'b1);
        end

        // Blinking cursor on an empty glyph at tile (4,0).
        for (int c = 0; c < 6; c++) tile_mem[{5'd0, 7'(c)}] = 7'h00;
        for (int i = 0; i < 16; i++) font_rom[i] = 8'h00;
        cursor_en_i  = 1'b1;
        cursor_col_i = 7'd4;
        cursor_row_i = 5'd0;
        step(700, 500, 1'b0, 1'b1, 1'b1);
        apply_reset();
        repeat (6) mini_frame();

        // Same frames with the cursor disabled.
        cursor_en_i = 1'b0;
        step(700, 500, 1'b0, 1'b1, 1'b1);
        apply_reset();
        repeat (4) mini_frame();

        repeat (4) step(700, 500, 1'b0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
